// File: rtl/instr_loader.sv
// Serial boot loader: 16-bit word count then N big-endian words into instruction memory, CPU held until done.
// Latency: one write cycle after every 4th accepted byte; in_ready drops during WRITE/DONE/ERROR to stall the source.
module instr_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic [15:0]       count;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        bidx;
  logic [31:0]       word;
  logic [15:0]       hdr_n;
  logic              hdr_zero;
  logic              hdr_over;
  logic              last_word;
  logic              rdy_state;
  logic              accept;

  // armed keeps in_ready low through reset and until the first clock edge after release
  assign rdy_state = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign in_ready  = armed & rdy_state;
  assign accept    = in_valid & in_ready;

  assign hdr_n     = {count[15:8], in_byte};
  assign hdr_zero  = (hdr_n == 16'd0);
  assign hdr_over  = (32'(hdr_n) > DEPTH);
  assign last_word = (32'(widx) == (32'(count) - 32'd1));

  assign mem_addr  = widx;
  assign mem_wdata = word;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= HDR_HI;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    cpu_run   = 1'b0;
    error     = 1'b0;
    case (state)
      HDR_HI: if (accept) state_nxt = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_zero)      state_nxt = DONE;
          else if (hdr_over) state_nxt = ERROR;
          else               state_nxt = DATA;
        end
      end
      DATA: if (accept && (bidx == 2'd3)) state_nxt = WRITE;
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_word ? DONE : DATA;
      end
      DONE: begin
        cpu_run = 1'b1;
        if (restart) state_nxt = HDR_HI;
      end
      ERROR: error = 1'b1;
      default: state_nxt = HDR_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 16'd0;
      widx      <= '0;
      bidx      <= 2'd0;
      word      <= 32'd0;
      load_done <= 1'b0;
    end else begin
      load_done <= (state_nxt == DONE) && (state != DONE);
      case (state)
        HDR_HI: if (accept) count[15:8] <= in_byte;
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_byte;
            widx       <= '0;
            bidx       <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            word <= {word[23:0], in_byte};
            bidx <= bidx + 2'd1;
          end
        end
        WRITE: begin
          // the index stops at N-1, so it never passes DEPTH-1
          if (!last_word) begin
            widx <= widx + ADDR_W'(1);
            bidx <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: header decode, word assembly, stalls, restart, error and reset abort.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        error;

  instr_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int ld_cnt = 0;
  int wb;
  int lb;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  stim[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_cyc.push_back(cyc);
      end
      if (load_done) ld_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  // maxgap>0 inserts idle cycles with junk data and random restart pulses
  task automatic send_stim(input int maxgap);
    int k;
    foreach (stim[i]) begin
      k = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      in_valid = 1'b0;
      for (int g = 0; g < k; g++) begin
        in_byte = 8'($urandom);
        restart = 1'($urandom_range(0, 1));
        tick();
      end
      restart = 1'b0;
      send_byte(stim[i]);
    end
  endtask

  task automatic do_reset();
    tick();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    restart  = 1'b0;
    tick();
    tick();
    check("rst_in_ready_low", 32'(in_ready), 0);
    reset_n = 1'b1;
    tick();
    check("rel_in_ready_high", 32'(in_ready), 1);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    restart  = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready), 0);
    check("rst_mem_we",    32'(mem_we), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_run",   32'(cpu_run), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_error",     32'(error), 0);
    reset_n = 1'b1;
    tick();
    check("first_edge_ready", 32'(in_ready), 1);

    // two-word load, in_valid held high
    wb = wr_addr.size();
    lb = ld_cnt;
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    check("load_cpu_held", 32'(cpu_run), 0);
    send_stim(0);
    repeat (4) tick();
    check("two_nwr",   32'(wr_addr.size() - wb), 2);
    check("two_addr0", 32'(wr_addr[wb]), 0);
    check("two_data0", wr_data[wb], 32'h20080005);
    check("two_addr1", 32'(wr_addr[wb+1]), 1);
    check("two_data1", wr_data[wb+1], 32'h01095020);
    check("two_spacing", 32'(wr_cyc[wb+1] - wr_cyc[wb]), 5);
    check("two_done_pulses", 32'(ld_cnt - lb), 1);
    check("two_cpu_run", 32'(cpu_run), 1);
    check("two_in_ready", 32'(in_ready), 0);

    // restart from DONE and reload one word
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_cpu_drop", 32'(cpu_run), 0);
    check("rs_in_ready", 32'(in_ready), 1);
    wb = wr_addr.size();
    lb = ld_cnt;
    stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stim(0);
    repeat (3) tick();
    check("rs_nwr",  32'(wr_addr.size() - wb), 1);
    check("rs_addr", 32'(wr_addr[wb]), 0);
    check("rs_data", wr_data[wb], 32'hDEADBEEF);
    check("rs_done_pulses", 32'(ld_cnt - lb), 1);
    check("rs_cpu_run", 32'(cpu_run), 1);

    // zero-length program
    do_reset();
    wb = wr_addr.size();
    lb = ld_cnt;
    stim = '{8'h00, 8'h00};
    send_stim(0);
    check("zero_cpu_run", 32'(cpu_run), 1);
    check("zero_load_done", 32'(load_done), 1);
    check("zero_in_ready", 32'(in_ready), 0);
    repeat (3) tick();
    check("zero_nwr", 32'(wr_addr.size() - wb), 0);
    check("zero_done_pulses", 32'(ld_cnt - lb), 1);

    // same two-word load with random in_valid gaps and ignored restart pulses
    do_reset();
    wb = wr_addr.size();
    lb = ld_cnt;
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send_stim(3);
    repeat (3) tick();
    check("gap_nwr",   32'(wr_addr.size() - wb), 2);
    check("gap_addr0", 32'(wr_addr[wb]), 0);
    check("gap_data0", wr_data[wb], 32'h20080005);
    check("gap_addr1", 32'(wr_addr[wb+1]), 1);
    check("gap_data1", wr_data[wb+1], 32'h01095020);
    check("gap_done_pulses", 32'(ld_cnt - lb), 1);
    check("gap_cpu_run", 32'(cpu_run), 1);

    // N = DEPTH is accepted
    do_reset();
    stim = '{8'h01, 8'h00};
    send_stim(0);
    check("max_error", 32'(error), 0);
    check("max_in_ready", 32'(in_ready), 1);

    // N = DEPTH+1 is rejected and sticky
    do_reset();
    wb = wr_addr.size();
    stim = '{8'h01, 8'h01};
    send_stim(0);
    check("ovr_error", 32'(error), 1);
    check("ovr_in_ready", 32'(in_ready), 0);
    check("ovr_cpu_run", 32'(cpu_run), 0);
    in_valid = 1'b1;
    restart  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_byte = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    tick();
    check("ovr_error_sticky", 32'(error), 1);
    check("ovr_no_write", 32'(wr_addr.size() - wb), 0);
    check("ovr_cpu_still_low", 32'(cpu_run), 0);
    do_reset();
    check("ovr_error_cleared", 32'(error), 0);

    // reset mid-load after 6 data bytes
    wb = wr_addr.size();
    stim = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stim(0);
    reset_n = 1'b0;
    tick();
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_cpu_run", 32'(cpu_run), 0);
    reset_n = 1'b1;
    tick();
    check("abort_nwr",   32'(wr_addr.size() - wb), 1);
    check("abort_addr0", 32'(wr_addr[wb]), 0);
    check("abort_data0", wr_data[wb], 32'h11223344);
    wb = wr_addr.size();
    lb = ld_cnt;
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send_stim(0);
    repeat (3) tick();
    check("reload_nwr",   32'(wr_addr.size() - wb), 2);
    check("reload_data0", wr_data[wb], 32'h20080005);
    check("reload_addr1", 32'(wr_addr[wb+1]), 1);
    check("reload_data1", wr_data[wb+1], 32'h01095020);
    check("reload_done_pulses", 32'(ld_cnt - lb), 1);
    check("reload_cpu_run", 32'(cpu_run), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
